// File: rtl/arr_port_mem.sv
// arr_port_mem: parametrised single-port array memory shared by a kernel port and a host port
module arr_port_mem #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 2,
    parameter int RD_LAT     = 1,
    parameter int WR_THROUGH = 0,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              controlArr,
    input  logic              ctl_wen,
    input  logic              ctl_ren,
    input  logic [ADDR_W-1:0] ctl_addr,
    input  logic [DATA_W-1:0] ctl_wdata,
    output logic [DATA_W-1:0] ctl_rdata,
    output logic              ctl_rvalid,
    input  logic              k_wen,
    input  logic              k_ren,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic [DATA_W-1:0] k_wdata,
    output logic [DATA_W-1:0] k_rdata,
    output logic              k_rvalid,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wen;
    logic              ren;
    logic              in_range;
    logic              iss_v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] iss_d;

    logic              fin_v;
    logic              fin_own;
    logic [DATA_W-1:0] fin_d;

    // Mux the owning port and form the result issued this cycle (tagged with controlArr at issue)
    always_comb begin
        wen      = controlArr ? ctl_wen : k_wen;
        ren      = controlArr ? ctl_ren : k_ren;
        addr     = controlArr ? ctl_addr : k_addr;
        wdata    = controlArr ? ctl_wdata : k_wdata;
        in_range = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
        iss_v    = (state == IDLE) && ((ren && !wen) || (wen && WR_THROUGH != 0));
        iss_d    = wen ? wdata : (in_range ? mem[addr] : '0);
    end

    // Storage: the clear sequencer owns the array while active, otherwise in-range writes land
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (wen && in_range)
            mem[addr] <= wdata;
    end

    // Clear sequencer: zero one word per cycle, then return to IDLE with a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s_v;
            logic              s_own;
            logic [DATA_W-1:0] s_d;

            // Extra pipeline stage carrying the result and its owner tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_v   <= 1'b0;
                    s_own <= 1'b0;
                    s_d   <= '0;
                end else begin
                    s_v   <= iss_v;
                    s_own <= controlArr;
                    s_d   <= iss_d;
                end
            end

            assign fin_v   = s_v;
            assign fin_own = s_own;
            assign fin_d   = s_d;
        end else begin : g_lat1
            assign fin_v   = iss_v;
            assign fin_own = controlArr;
            assign fin_d   = iss_d;
        end
    endgenerate

    // Route results to the tagged owner; rdata holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_rvalid <= 1'b0;
            k_rvalid   <= 1'b0;
            ctl_rdata  <= '0;
            k_rdata    <= '0;
        end else begin
            ctl_rvalid <= fin_v && fin_own;
            k_rvalid   <= fin_v && !fin_own;
            if (fin_v && fin_own)
                ctl_rdata <= fin_d;
            if (fin_v && !fin_own)
                k_rdata <= fin_d;
        end
    end
endmodule

// File: tb/tb_arr_port_mem.sv
// tb_arr_port_mem: two configurations of arr_port_mem driven in parallel and checked against a behavioural model
module tb_arr_port_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        controlArr = 1'b0;
    logic        ctl_wen = 1'b0;
    logic        ctl_ren = 1'b0;
    logic        k_wen = 1'b0;
    logic        k_ren = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  ctl_addr = '0;
    logic [2:0]  k_addr = '0;
    logic [15:0] ctl_wdata = '0;
    logic [15:0] k_wdata = '0;

    logic [15:0] c_rd [2];
    logic [15:0] k_rd [2];
    logic        c_rv [2];
    logic        k_rv [2];
    logic        bsy  [2];
    logic        cdn  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arr_port_mem #(.DATA_W(16), .DEPTH(5), .RD_LAT(1), .WR_THROUGH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .controlArr(controlArr),
        .ctl_wen(ctl_wen), .ctl_ren(ctl_ren), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_rdata(c_rd[0]), .ctl_rvalid(c_rv[0]),
        .k_wen(k_wen), .k_ren(k_ren), .k_addr(k_addr), .k_wdata(k_wdata),
        .k_rdata(k_rd[0]), .k_rvalid(k_rv[0]),
        .clear_req(clear_req), .busy(bsy[0]), .clear_done(cdn[0])
    );

    arr_port_mem #(.DATA_W(16), .DEPTH(6), .RD_LAT(2), .WR_THROUGH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .controlArr(controlArr),
        .ctl_wen(ctl_wen), .ctl_ren(ctl_ren), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_rdata(c_rd[1]), .ctl_rvalid(c_rv[1]),
        .k_wen(k_wen), .k_ren(k_ren), .k_addr(k_addr), .k_wdata(k_wdata),
        .k_rdata(k_rd[1]), .k_rvalid(k_rv[1]),
        .clear_req(clear_req), .busy(bsy[1]), .clear_done(cdn[1])
    );

    task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] at %0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Model: results wait in a queue until their due cycle, then land on the owner tagged at issue
    typedef struct {
        int          inst;
        int          due;
        bit          own;
        logic [15:0] d;
    } res_t;

    res_t        pq [$];
    int          depth_m [2] = '{5, 6};
    int          lat_m   [2] = '{1, 2};
    bit          wt_m    [2] = '{1'b0, 1'b1};
    logic [15:0] mm [2][8];
    bit          busy_m [2];
    bit          done_m [2];
    int          cnt_m  [2];
    bit          ev [2][2];
    logic [15:0] er [2][2];
    int          cyc = 0;
    bit          m_h, m_w, m_r;
    int          m_a;
    logic [15:0] m_wd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            for (int i = 0; i < 2; i++) begin
                busy_m[i] = 0;
                done_m[i] = 0;
                cnt_m[i]  = 0;
                for (int o = 0; o < 2; o++) begin
                    ev[i][o] = 0;
                    er[i][o] = '0;
                end
            end
        end else begin
            cyc++;
            m_h  = controlArr;
            m_w  = m_h ? ctl_wen : k_wen;
            m_r  = m_h ? ctl_ren : k_ren;
            m_a  = int'(m_h ? ctl_addr : k_addr);
            m_wd = m_h ? ctl_wdata : k_wdata;
            for (int i = 0; i < 2; i++) begin
                done_m[i] = 0;
                if (busy_m[i]) begin
                    mm[i][cnt_m[i]] = '0;
                    cnt_m[i]++;
                    if (cnt_m[i] == depth_m[i]) begin
                        busy_m[i] = 0;
                        done_m[i] = 1;
                    end
                end else begin
                    if (m_w) begin
                        if (m_a < depth_m[i]) mm[i][m_a] = m_wd;
                        if (wt_m[i]) pq.push_back('{i, cyc + lat_m[i] - 1, m_h, m_wd});
                    end else if (m_r) begin
                        pq.push_back('{i, cyc + lat_m[i] - 1, m_h, (m_a < depth_m[i]) ? mm[i][m_a] : 16'h0});
                    end
                    if (clear_req) begin
                        busy_m[i] = 1;
                        cnt_m[i]  = 0;
                    end
                end
                ev[i][0] = 0;
                ev[i][1] = 0;
            end
            for (int j = pq.size() - 1; j >= 0; j--) begin
                if (pq[j].due == cyc) begin
                    ev[pq[j].inst][pq[j].own] = 1;
                    er[pq[j].inst][pq[j].own] = pq[j].d;
                    pq.delete(j);
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("ctl_rvalid", i, 16'(c_rv[i]), 16'(ev[i][1]));
            chk("k_rvalid", i, 16'(k_rv[i]), 16'(ev[i][0]));
            chk("busy", i, 16'(bsy[i]), 16'(busy_m[i]));
            chk("clear_done", i, 16'(cdn[i]), 16'(done_m[i]));
            if (ev[i][1] || !rst_n) chk("ctl_rdata", i, c_rd[i], er[i][1]);
            if (ev[i][0] || !rst_n) chk("k_rdata", i, k_rd[i], er[i][0]);
        end
    end

    task automatic drive(bit h, bit w, bit r, logic [2:0] a, logic [15:0] d, bit clr = 1'b0);
        controlArr = h;
        if (h) begin
            ctl_wen = w; ctl_ren = r; ctl_addr = a; ctl_wdata = d;
        end else begin
            k_wen = w; k_ren = r; k_addr = a; k_wdata = d;
        end
        clear_req = clr;
        @(posedge clk);
        #2;
        ctl_wen = 0; ctl_ren = 0; k_wen = 0; k_ren = 0; clear_req = 0;
    endtask

    task automatic nop(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int nb;
    int exp6 [6] = '{0, 0, 3, 4, 5, 0};

    initial begin
        nop(3);
        rst_n = 1;
        for (int a = 0; a < 6; a++) drive(0, 1, 0, 3'(a), 16'(16'h100 + a));
        // kernel writes then back-to-back reads
        drive(0, 1, 0, 3'd0, 16'h5);
        drive(0, 1, 0, 3'd1, 16'h7);
        drive(0, 0, 1, 3'd0, 16'h0);
        chk("t1_rv0", 0, 16'(k_rv[0]), 16'h1);
        chk("t1_rd0", 0, k_rd[0], 16'h5);
        drive(0, 0, 1, 3'd1, 16'h0);
        chk("t1_rv1", 0, 16'(k_rv[0]), 16'h1);
        chk("t1_rd1", 0, k_rd[0], 16'h7);
        chk("t1_ctl_rv", 0, 16'(c_rv[0]), 16'h0);
        chk("t1_lat2_rd0", 1, k_rd[1], 16'h5);
        nop(1);
        chk("t1_lat2_rd1", 1, k_rd[1], 16'h7);
        // host read, ownership dropped while in flight
        drive(1, 0, 1, 3'd1, 16'h0);
        chk("t2_lat1_rd", 0, c_rd[0], 16'h7);
        drive(0, 0, 0, 3'd0, 16'h0);
        chk("t2_ctl_rv", 1, 16'(c_rv[1]), 16'h1);
        chk("t2_ctl_rd", 1, c_rd[1], 16'h7);
        chk("t2_k_rv", 1, 16'(k_rv[1]), 16'h0);
        // write-through readback
        drive(0, 1, 0, 3'd0, 16'hBEEF);
        chk("t3_no_wt", 0, 16'(k_rv[0]), 16'h0);
        nop(1);
        chk("t3_wt_rv", 1, 16'(k_rv[1]), 16'h1);
        chk("t3_wt_rd", 1, k_rd[1], 16'hBEEF);
        drive(0, 0, 1, 3'd0, 16'h0);
        chk("t3_rd", 0, k_rd[0], 16'hBEEF);
        // out-of-range access
        drive(0, 1, 0, 3'd5, 16'h9);
        drive(0, 0, 1, 3'd5, 16'h0);
        chk("t4_oor_rv", 0, 16'(k_rv[0]), 16'h1);
        chk("t4_oor_rd", 0, k_rd[0], 16'h0);
        nop(1);
        chk("t4_inrange_rd", 1, k_rd[1], 16'h9);
        drive(0, 1, 0, 3'd7, 16'hA);
        drive(0, 0, 1, 3'd7, 16'h0);
        nop(1);
        // inactive kernel port must have no effect while the host owns the array
        controlArr = 1; k_wen = 1; k_addr = 3'd2; k_wdata = 16'hDEAD;
        ctl_ren = 1; ctl_addr = 3'd2;
        @(posedge clk);
        #2;
        k_wen = 0; ctl_ren = 0;
        drive(0, 0, 1, 3'd2, 16'h0);
        chk("inactive_port", 0, k_rd[0], 16'h102);
        // write wins over read in the same cycle
        drive(1, 1, 1, 3'd3, 16'h3333);
        chk("write_wins", 0, 16'(c_rv[0]), 16'h0);
        // continuous read stream alternating owners
        for (int a = 0; a < 5; a++) drive(bit'(a % 2), 0, 1, 3'(a), 16'h0);
        nop(2);
        // clear sequence with reads requested while busy
        for (int a = 0; a < 6; a++) drive(0, 1, 0, 3'(a), 16'(a + 1));
        drive(0, 0, 1, 3'd1, 16'h0, 1'b1);
        chk("t5_same_cycle_rd", 0, k_rd[0], 16'h2);
        nb = 0;
        for (int c = 0; c < 12 && !cdn[0]; c++) begin
            if (bsy[0]) nb++;
            drive(0, 0, 1, 3'(c % 5), 16'h0, c == 2);
        end
        chk("t5_busy_cycles", 0, 16'(nb), 16'd5);
        chk("t5_done", 0, 16'(cdn[0]), 16'h1);
        chk("t5_busy_at_done", 0, 16'(bsy[0]), 16'h0);
        nop(2);
        for (int a = 0; a < 6; a++) begin
            drive(0, 0, 1, 3'(a), 16'h0);
            chk("t5_cleared", 0, k_rd[0], 16'h0);
        end
        nop(2);
        // reset with a read in flight
        drive(0, 0, 1, 3'd2, 16'h0);
        rst_n = 0;
        #1;
        chk("rst_k_rv", 0, 16'(k_rv[0]), 16'h0);
        chk("rst_k_rd", 0, k_rd[0], 16'h0);
        nop(1);
        rst_n = 1;
        nop(3);
        // reset during the clear
        for (int a = 0; a < 6; a++) drive(0, 1, 0, 3'(a), 16'(a + 1));
        drive(0, 0, 0, 3'd0, 16'h0, 1'b1);
        nop(2);
        rst_n = 0;
        #1;
        chk("t6_busy", 0, 16'(bsy[0]), 16'h0);
        chk("t6_busy_b", 1, 16'(bsy[1]), 16'h0);
        nop(1);
        rst_n = 1;
        nop(8);
        for (int a = 0; a < 6; a++) begin
            drive(0, 0, 1, 3'(a), 16'h0);
            chk("t6_word", 0, k_rd[0], 16'(exp6[a]));
        end
        nop(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
